alu_flag_stage: RTL and testbench
=================================

ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  — single clock; all state updates on its rising edge.
- reset_n  input  1  — asynchronous, active-low reset.
- in_valid  input  1  — operand/op presented this cycle.
- in_ready  output  1  — stage can accept this cycle.
- a  input  32  — operand A (two's complement).
- b  input  32  — operand B; b[4:0] is the shift amount for shifts.
- alu_op  input  4  — operation select (REQ-010).
- flush  input  1  — synchronous discard of the held entry.
- out_ready  input  1  — downstream comparator/writeback accepts.
- out_valid  output  1  — registered result valid.
- result  output  32  — registered result.
- z, v, n  output  1 each  — registered zero/overflow/negative flags for the comparator.
- op_q  output  4  — registered alu_op aligned with result; the comparator takes op_q[3] and op_q[1].
- ovf_sticky  output  1  — set by any accepted add/sub/compare that overflows.
- clr_ovf  input  1  — synchronous clear of ovf_sticky.

Function
REQ-010 Encoding SHALL be: 0000 add, 0001 sub, 0010 and, 0011 or, 0101 xor, 0111 nor, 1000 sll, 1001 srl, 1011 sra, 0100 cmpeq, 0110 cmplt, 1100 cmple; 1010, 1101, 1110, 1111 reserved.
REQ-011 Add/sub SHALL be 32-bit modulo; compares SHALL compute a-b into result.
REQ-012 Shifts SHALL use b[4:0] only; sra SHALL replicate a[31].
REQ-013 Reserved ops SHALL produce result 0, z=1, n=0, v=0.
REQ-014 z SHALL equal (result==0); n SHALL equal result[31].
REQ-015 v SHALL be signed overflow for add (equal operand signs, result sign differs) and for sub/compares (operand signs differ, result sign differs from a[31]); v SHALL be 0 for all other ops.
REQ-016 The stage SHALL be one register deep: in_ready = !out_valid || out_ready (combinational).
REQ-017 Capture SHALL occur when in_valid && in_ready && !flush; result, z, v, n, op_q load on that edge; latency one cycle.
REQ-018 With out_valid=1 and out_ready=0, result/flags/op_q SHALL hold stable.
REQ-019 out_valid next state: 0 if flush; else 1 if capture; else 0 if out_ready; else unchanged.
REQ-020 Simultaneous drain and capture (out_valid=1, out_ready=1, in_valid=1) SHALL replace the entry with no bubble.
REQ-021 flush SHALL win over capture and drain; data registers may hold stale values while out_valid=0.
REQ-022 ovf_sticky SHALL set on capture of an op with v=1; clear on clr_ovf otherwise; set wins when both occur in one cycle.

Reset
REQ-030 reset_n low SHALL immediately force out_valid=0, result=0, z=1, v=0, n=0, op_q=0000, ovf_sticky=0, independent of clk.
REQ-031 Reset asserted mid-transfer SHALL discard the held entry; no output valid until a new capture after release.
REQ-032 in_ready SHALL be 1 during and after reset.

Verification
REQ-040 add a=7FFFFFFF, b=1, out_ready=1 -> next cycle result=80000000, v=1, n=1, z=0, out_valid=1, ovf_sticky=1.
REQ-041 cmplt a=FFFFFFFE (-2), b=3 -> result=FFFFFFFB, n=1, v=0, z=0, op_q=0110; cmpeq a=b=5 -> z=1.
REQ-042 sra a=80000000, b=00000024 -> result=F8000000 (shift 4); srl same operands -> 08000000.
REQ-043 Backpressure: capture add 1+2, out_ready=0 for 3 cycles with new in_valid -> in_ready=0, result holds 3; out_ready=1 with in_valid (sub 9-4) -> result 5 next cycle, no bubble.
REQ-044 flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, no capture; clr_ovf coincident with overflowing capture -> ovf_sticky=1.
REQ-045 reset_n pulsed low between clk edges while out_valid=1 -> out_valid=0, z=1 immediately; reserved op 1111 after release -> result=0, z=1.

Source files
------------

// File: rtl/alu_flag_stage.sv
// alu_flag_stage: one-deep registered ALU stage producing result, z/v/n flags and a sticky overflow bit
module alu_flag_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_op,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        z,
  output logic        v,
  output logic        n,
  output logic [3:0]  op_q,
  output logic        ovf_sticky,
  input  logic        clr_ovf
);
  logic [31:0] sum, diff, r;
  logic        ov, cap;
  assign sum = a + b;
  assign diff = a - b;
  assign in_ready = !out_valid || out_ready;
  assign cap = in_valid && in_ready && !flush;
  always_comb begin
    r = '0;
    ov = 1'b0;
    case (alu_op)
      4'b0000: begin
        r = sum;
        ov = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      4'b0001, 4'b0100, 4'b0110, 4'b1100: begin
        r = diff;
        ov = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0101: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1000: r = a << b[4:0];
      4'b1001: r = a >> b[4:0];
      4'b1011: r = $unsigned($signed(a) >>> b[4:0]);
      default: r = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result <= '0;
      z <= 1'b1;
      v <= 1'b0;
      n <= 1'b0;
      op_q <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      out_valid <= flush ? 1'b0 : cap ? 1'b1 : out_ready ? 1'b0 : out_valid;
      ovf_sticky <= (cap && ov) ? 1'b1 : clr_ovf ? 1'b0 : ovf_sticky;
      if (cap) begin
        result <= r;
        z <= (r == '0);
        v <= ov;
        n <= r[31];
        op_q <= alu_op;
      end
    end
  end
endmodule

// File: tb/tb_alu_flag_stage.sv
// tb_alu_flag_stage: directed-vector bench for alu_flag_stage with hand-computed expectations
module tb_alu_flag_stage;
  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, flush, out_ready, out_valid;
  logic        z, v, n, ovf_sticky, clr_ovf;
  logic [31:0] a, b, result;
  logic [3:0]  alu_op, op_q;
  int n_chk = 0;
  int n_fail = 0;

  alu_flag_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .result(result), .z(z), .v(v), .n(n),
    .op_q(op_q), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
    in_valid = vld;
    alu_op = op;
    a = aa;
    b = bb;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] r, input logic [3:0] fl);
    chk({tag, "_result"}, result, r);
    chk({tag, "_zvn"}, {29'd0, z, v, n}, {29'd0, fl[2:0]});
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, fl[3]});
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    clr_ovf = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zvn", {29'd0, z, v, n}, 32'b100);
    chk("rst_opq", {28'd0, op_q}, 32'd0);
    chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset_n = 1'b1;
    drive(1'b1, 4'b0000, 32'h7FFF_FFFF, 32'h1);
    cyc;
    chk_out("add_ovf", 32'h8000_0000, 4'b1011);
    chk("add_ovf_sticky", {31'd0, ovf_sticky}, 32'd1);
    drive(1'b1, 4'b0110, 32'hFFFF_FFFE, 32'h3);
    cyc;
    chk_out("cmplt", 32'hFFFF_FFFB, 4'b1001);
    chk("cmplt_opq", {28'd0, op_q}, 32'h6);
    drive(1'b1, 4'b0100, 32'h5, 32'h5);
    cyc;
    chk_out("cmpeq", 32'h0, 4'b1100);
    drive(1'b1, 4'b1011, 32'h8000_0000, 32'h24);
    cyc;
    chk_out("sra", 32'hF800_0000, 4'b1001);
    drive(1'b1, 4'b1001, 32'h8000_0000, 32'h24);
    cyc;
    chk_out("srl", 32'h0800_0000, 4'b1000);
    drive(1'b1, 4'b1000, 32'h1, 32'h3F);
    cyc;
    chk_out("sll31", 32'h8000_0000, 4'b1001);
    drive(1'b1, 4'b0001, 32'h8000_0000, 32'h1);
    cyc;
    chk_out("sub_ovf", 32'h7FFF_FFFF, 4'b1010);
    drive(1'b1, 4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00);
    clr_ovf = 1'b1;
    cyc;
    clr_ovf = 1'b0;
    chk_out("xor", 32'h0FF0_0FF0, 4'b1000);
    chk("clr_sticky", {31'd0, ovf_sticky}, 32'd0);
    drive(1'b1, 4'b0000, 32'h1, 32'h2);
    cyc;
    chk_out("bp_add", 32'h3, 4'b1000);
    out_ready = 1'b0;
    drive(1'b1, 4'b0000, 32'h64, 32'h1);
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk_out("bp_hold", 32'h3, 4'b1000);
      chk("bp_hold_opq", {28'd0, op_q}, 32'h0);
    end
    out_ready = 1'b1;
    drive(1'b1, 4'b0001, 32'h9, 32'h4);
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    cyc;
    chk_out("bp_sub", 32'h5, 4'b1000);
    flush = 1'b1;
    drive(1'b1, 4'b0000, 32'h77, 32'h0);
    cyc;
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_no_cap", result, 32'h5);
    drive(1'b1, 4'b0000, 32'h7FFF_FFFF, 32'h1);
    clr_ovf = 1'b1;
    cyc;
    clr_ovf = 1'b0;
    chk("set_wins_sticky", {31'd0, ovf_sticky}, 32'd1);
    chk_out("set_wins", 32'h8000_0000, 4'b1011);
    drive(1'b1, 4'b0111, 32'h0, 32'h0);
    cyc;
    chk_out("nor", 32'hFFFF_FFFF, 4'b1001);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    out_ready = 1'b0;
    cyc;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_rst", 32'h0, 4'b0100);
    chk("async_rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    #1;
    reset_n = 1'b1;
    cyc;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 4'b1111, 32'h5, 32'h3);
    cyc;
    chk_out("reserved", 32'h0, 4'b1100);
    chk("reserved_opq", {28'd0, op_q}, 32'hF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
